// File: rtl/menshen_cam_pkg.sv
// Shared constants and write-FSM encoding for the menshen TCAM match stage.
// Consumed by tcam_match_engine and tcam_prio_enc.
package menshen_cam_pkg;

    localparam int DEF_DEPTH     = 16;
    localparam int DEF_ADDR_BITS = 4;
    localparam int DEF_WIDTH     = 205;
    localparam int STAT_W        = 32;

    typedef enum logic {
        WR_IDLE   = 1'b0,
        WR_COMMIT = 1'b1
    } wr_state_t;

endpackage

// File: rtl/tcam_prio_enc.sv
// Combinational lowest-index priority encoder with any-hit and multi-hit flags.
// addr is 0 when no bit of hit is set.
module tcam_prio_enc
    import menshen_cam_pkg::*;
#(
    parameter int C_DEPTH   = DEF_DEPTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic [C_DEPTH-1:0]   hit,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 any,
    output logic                 multi
);

    // Scanning downwards leaves the lowest set index in addr.
    always_comb begin
        addr  = '0;
        any   = 1'b0;
        multi = 1'b0;
        for (int i = C_DEPTH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                multi = multi | any;
                any   = 1'b1;
                addr  = ADDR_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/tcam_match_engine.sv
// Ternary CAM with a 2-stage lookup pipeline and a 2-cycle write port.
// Optional lookup/hit counters are enabled with the TCAM_STATS_EN macro.
module tcam_match_engine
    import menshen_cam_pkg::*;
#(
    parameter int C_DEPTH   = DEF_DEPTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int C_WIDTH   = DEF_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CMP_VALID,
    output logic                 CMP_READY,
    input  logic [C_WIDTH-1:0]   CMP_DIN,
    output logic                 MATCH_VALID,
    input  logic                 MATCH_READY,
    output logic                 MATCH,
    output logic                 MATCH_MULTI,
    output logic [ADDR_BITS-1:0] MATCH_ADDR,
    input  logic                 WE,
    input  logic                 WR_DELETE,
    input  logic [ADDR_BITS-1:0] WR_ADDR,
    input  logic [C_WIDTH-1:0]   DIN,
    input  logic [C_WIDTH-1:0]   DIN_MASK,
    output logic                 BUSY,
    output logic [STAT_W-1:0]    STAT_LOOKUPS,
    output logic [STAT_W-1:0]    STAT_HITS
);

    logic [C_WIDTH-1:0]   value_mem [C_DEPTH];
    logic [C_WIDTH-1:0]   mask_mem  [C_DEPTH];
    logic [C_DEPTH-1:0]   entry_vld;

    wr_state_t            wr_state;
    logic                 busy_r;
    logic [ADDR_BITS-1:0] wr_addr_q;
    logic [C_WIDTH-1:0]   wr_value_q;
    logic [C_WIDTH-1:0]   wr_mask_q;
    logic                 wr_del_q;

    logic [C_DEPTH-1:0]   hit_c;
    logic                 advance;
    logic                 accept;

    logic                 vld_p1;
    logic [C_DEPTH-1:0]   hit_p1;
    logic [ADDR_BITS-1:0] enc_addr;
    logic                 enc_any;
    logic                 enc_multi;

    logic                 vld_p2;
    logic                 match_p2;
    logic                 multi_p2;
    logic [ADDR_BITS-1:0] addr_p2;

    // WE is only looked at in IDLE, so a request during COMMIT is dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_state  <= WR_IDLE;
            busy_r    <= 1'b0;
            entry_vld <= '0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (WE) begin
                        wr_addr_q  <= WR_ADDR;
                        wr_value_q <= DIN;
                        wr_mask_q  <= DIN_MASK;
                        wr_del_q   <= WR_DELETE;
                        wr_state   <= WR_COMMIT;
                        busy_r     <= 1'b1;
                    end
                end
                WR_COMMIT: begin
                    entry_vld[wr_addr_q] <= !wr_del_q;
                    wr_state             <= WR_IDLE;
                    busy_r               <= 1'b0;
                end
                default: begin
                    wr_state <= WR_IDLE;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && wr_state == WR_COMMIT && !wr_del_q) begin
            value_mem[wr_addr_q] <= wr_value_q;
            mask_mem[wr_addr_q]  <= wr_mask_q;
        end
    end

    always_comb begin
        hit_c = '0;
        for (int i = 0; i < C_DEPTH; i++) begin
            hit_c[i] = entry_vld[i] & ~|((CMP_DIN ^ value_mem[i]) & mask_mem[i]);
        end
    end

    assign advance   = !vld_p2 | MATCH_READY;
    assign CMP_READY = advance & !RST;
    assign accept    = CMP_VALID & CMP_READY;

    // ---- stage p1: per-entry hit vector ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1 <= 1'b0;
        end else if (advance) begin
            vld_p1 <= accept;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            hit_p1 <= hit_c;
        end
    end

    tcam_prio_enc #(
        .C_DEPTH   (C_DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_prio_enc (
        .hit   (hit_p1),
        .addr  (enc_addr),
        .any   (enc_any),
        .multi (enc_multi)
    );

    // ---- stage p2: encoded result ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p2   <= 1'b0;
            match_p2 <= 1'b0;
            multi_p2 <= 1'b0;
            addr_p2  <= '0;
        end else if (advance) begin
            vld_p2   <= vld_p1;
            match_p2 <= vld_p1 & enc_any;
            multi_p2 <= vld_p1 & enc_multi;
            addr_p2  <= vld_p1 ? enc_addr : '0;
        end
    end

    assign MATCH_VALID = vld_p2;
    assign MATCH       = match_p2;
    assign MATCH_MULTI = multi_p2;
    assign MATCH_ADDR  = addr_p2;
    assign BUSY        = busy_r;

`ifdef TCAM_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [STAT_W-1:0] lookups_q;
    logic [STAT_W-1:0] hits_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            lookups_q <= '0;
            hits_q    <= '0;
        end else begin
            if (accept) begin
                lookups_q <= sat_inc(lookups_q);
            end
            if (vld_p2 && MATCH_READY && match_p2) begin
                hits_q <= sat_inc(hits_q);
            end
        end
    end

    assign STAT_LOOKUPS = lookups_q;
    assign STAT_HITS    = hits_q;
`else
    assign STAT_LOOKUPS = '0;
    assign STAT_HITS    = '0;
`endif

endmodule

// File: tb/tb_tcam_match_engine.sv
// Self-checking bench for tcam_match_engine: directed tables, hand-written
// corner sequences and randomized lookups against a behavioural TCAM model.
module tb_tcam_match_engine;

    localparam int W = 205;
    localparam int D = 16;
`ifdef TCAM_STATS_EN
    localparam int EXP_LK = 10;
    localparam int EXP_HT = 6;
`else
    localparam int EXP_LK = 0;
    localparam int EXP_HT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         cmp_valid;
    logic         cmp_ready;
    logic [W-1:0] cmp_din;
    logic         match_valid;
    logic         match_ready;
    logic         match;
    logic         match_multi;
    logic [3:0]   match_addr;
    logic         we;
    logic         wr_delete;
    logic [3:0]   wr_addr;
    logic [W-1:0] din;
    logic [W-1:0] din_mask;
    logic         busy;
    logic [31:0]  stat_lookups;
    logic [31:0]  stat_hits;

    tcam_match_engine dut (
        .CLK          (clk),
        .RST          (rst),
        .CMP_VALID    (cmp_valid),
        .CMP_READY    (cmp_ready),
        .CMP_DIN      (cmp_din),
        .MATCH_VALID  (match_valid),
        .MATCH_READY  (match_ready),
        .MATCH        (match),
        .MATCH_MULTI  (match_multi),
        .MATCH_ADDR   (match_addr),
        .WE           (we),
        .WR_DELETE    (wr_delete),
        .WR_ADDR      (wr_addr),
        .DIN          (din),
        .DIN_MASK     (din_mask),
        .BUSY         (busy),
        .STAT_LOOKUPS (stat_lookups),
        .STAT_HITS    (stat_hits)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit       m;
        bit       mm;
        bit [3:0] a;
    } res_t;

    typedef struct {
        logic [7:0] key;
        bit         m;
        bit         mm;
        bit [3:0]   a;
    } vec_t;

    int     n_cmp = 0;
    int     n_fail = 0;
    bit [W-1:0] m_val  [D];
    bit [W-1:0] m_mask [D];
    bit         m_vld  [D];
    res_t   exp_q [$];
    vec_t   tbl [8];

    function automatic bit [W-1:0] wk(input logic [7:0] k);
        return {{(W-8){1'b0}}, k};
    endfunction

    function automatic bit [W-1:0] mk(input logic [7:0] m);
        return {{(W-8){1'b1}}, m};
    endfunction

    // Reference: count every matching valid entry, remember the first one.
    function automatic res_t ref_lookup(input logic [7:0] key);
        res_t r;
        int   cnt;
        r   = '0;
        cnt = 0;
        for (int i = 0; i < D; i++) begin
            if (m_vld[i] && (((wk(key) ^ m_val[i]) & m_mask[i]) == '0)) begin
                if (cnt == 0) r.a = 4'(i);
                cnt++;
            end
        end
        r.m  = (cnt > 0);
        r.mm = (cnt > 1);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input bit cv, input logic [7:0] key, input bit mr);
        res_t e;
        cmp_valid   = cv;
        cmp_din     = wk(key);
        match_ready = mr;
        #1;
        if (cv && cmp_ready) exp_q.push_back(ref_lookup(key));
        if (match_valid && mr) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_match", {31'd0, match}, {31'd0, e.m});
                chk("sb_multi", {31'd0, match_multi}, {31'd0, e.mm});
                chk("sb_addr", {28'd0, match_addr}, {28'd0, e.a});
            end
        end
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic do_write(input logic [3:0] a, input bit [W-1:0] v, input bit [W-1:0] m, input bit del);
        cmp_valid   = 1'b0;
        match_ready = 1'b1;
        we = 1'b1; wr_addr = a; din = v; din_mask = m; wr_delete = del;
        #1;
        chk("busy_before_wr", {31'd0, busy}, 32'd0);
        tick();
        we = 1'b0;
        chk("busy_commit", {31'd0, busy}, 32'd1);
        tick();
        chk("busy_after_wr", {31'd0, busy}, 32'd0);
        if (del) begin
            m_vld[a] = 1'b0;
        end else begin
            m_val[a] = v; m_mask[a] = m; m_vld[a] = 1'b1;
        end
    endtask

    // One isolated lookup with fixed expected values and a 2-cycle latency check.
    task automatic apply_vec(input vec_t v);
        cmp_valid = 1'b1; cmp_din = wk(v.key); match_ready = 1'b1;
        #1;
        chk("vec_cmp_ready", {31'd0, cmp_ready}, 32'd1);
        tick();
        cmp_valid = 1'b0;
        chk("vec_lat1_valid", {31'd0, match_valid}, 32'd0);
        tick();
        chk("vec_valid", {31'd0, match_valid}, 32'd1);
        chk("vec_match", {31'd0, match}, {31'd0, v.m});
        chk("vec_multi", {31'd0, match_multi}, {31'd0, v.mm});
        chk("vec_addr", {28'd0, match_addr}, {28'd0, v.a});
        tick();
        chk("vec_consumed", {31'd0, match_valid}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        res_t       e0;
        logic [7:0] k;
        bit [W-1:0] msk;

        tbl[0] = '{8'hA5, 1'b1, 1'b0, 4'd3};
        tbl[1] = '{8'hA4, 1'b0, 1'b0, 4'd0};
        tbl[2] = '{8'h11, 1'b1, 1'b1, 4'd2};
        tbl[3] = '{8'hA5, 1'b1, 1'b1, 4'd2};
        tbl[4] = '{8'h00, 1'b1, 1'b0, 4'd2};
        tbl[5] = '{8'h11, 1'b1, 1'b0, 4'd5};
        tbl[6] = '{8'hA5, 1'b1, 1'b0, 4'd3};
        tbl[7] = '{8'hA4, 1'b0, 1'b0, 4'd0};

        for (int i = 0; i < D; i++) begin
            m_val[i] = '0; m_mask[i] = '0; m_vld[i] = 1'b0;
        end

        rst = 1'b1; cmp_valid = 1'b1; cmp_din = '0; match_ready = 1'b1;
        we = 1'b0; wr_delete = 1'b0; wr_addr = '0; din = '0; din_mask = '0;
        repeat (3) tick();
        chk("rst_cmp_ready", {31'd0, cmp_ready}, 32'd0);
        chk("rst_match_valid", {31'd0, match_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_match", {31'd0, match}, 32'd0);
        chk("rst_multi", {31'd0, match_multi}, 32'd0);
        chk("rst_addr", {28'd0, match_addr}, 32'd0);
        chk("rst_stat_lk", stat_lookups, 32'd0);
        chk("rst_stat_ht", stat_hits, 32'd0);
        rst = 1'b0; cmp_valid = 1'b0;
        tick();

        // Directed table phases with writes in between.
        do_write(4'd3, wk(8'hA5), mk(8'hFF), 1'b0);
        for (int i = 0; i < 2; i++) apply_vec(tbl[i]);
        do_write(4'd2, wk(8'h00), '0, 1'b0);
        do_write(4'd5, wk(8'h11), mk(8'hFF), 1'b0);
        for (int i = 2; i < 5; i++) apply_vec(tbl[i]);
        do_write(4'd2, '0, '0, 1'b1);
        for (int i = 5; i < 8; i++) apply_vec(tbl[i]);

        // WE on two consecutive cycles: the second lands in COMMIT and is lost.
        we = 1'b1; wr_addr = 4'd9; din = wk(8'h99); din_mask = mk(8'hFF); wr_delete = 1'b0;
        #1;
        chk("dbl_busy0", {31'd0, busy}, 32'd0);
        tick();
        wr_addr = 4'd10; din = wk(8'h9A);
        chk("dbl_busy1", {31'd0, busy}, 32'd1);
        tick();
        we = 1'b0;
        chk("dbl_busy2", {31'd0, busy}, 32'd0);
        tick();
        chk("dbl_busy3", {31'd0, busy}, 32'd0);
        m_val[9] = wk(8'h99); m_mask[9] = mk(8'hFF); m_vld[9] = 1'b1;
        apply_vec('{8'h99, 1'b1, 1'b0, 4'd9});
        apply_vec('{8'h9A, 1'b0, 1'b0, 4'd0});

        // Lookups at COMMIT and COMMIT+1 against a rewrite of entry 7.
        do_write(4'd7, wk(8'h77), mk(8'hFF), 1'b0);
        we = 1'b1; wr_addr = 4'd7; din = wk(8'h78); din_mask = mk(8'hFF); wr_delete = 1'b0;
        cmp_valid = 1'b0; match_ready = 1'b1;
        tick();
        we = 1'b0; cmp_valid = 1'b1; cmp_din = wk(8'h78);
        #1;
        chk("ovl_busy_commit", {31'd0, busy}, 32'd1);
        chk("ovl_rdy0", {31'd0, cmp_ready}, 32'd1);
        tick();
        #1;
        chk("ovl_rdy1", {31'd0, cmp_ready}, 32'd1);
        tick();
        cmp_valid = 1'b0;
        chk("ovl_old_valid", {31'd0, match_valid}, 32'd1);
        chk("ovl_old_match", {31'd0, match}, 32'd0);
        tick();
        chk("ovl_new_valid", {31'd0, match_valid}, 32'd1);
        chk("ovl_new_match", {31'd0, match}, 32'd1);
        chk("ovl_new_addr", {28'd0, match_addr}, 32'd7);
        tick();
        m_val[7] = wk(8'h78);

        // Back-pressure: results held stable for 4 cycles, then drained in order.
        cyc(1'b1, 8'hA5, 1'b0);
        cyc(1'b1, 8'h11, 1'b0);
        e0 = exp_q[0];
        for (int i = 0; i < 4; i++) begin
            cmp_valid = 1'b1; cmp_din = wk(8'h55); match_ready = 1'b0;
            #1;
            chk("stall_cmp_ready", {31'd0, cmp_ready}, 32'd0);
            chk("stall_valid", {31'd0, match_valid}, 32'd1);
            chk("stall_match", {31'd0, match}, {31'd0, e0.m});
            chk("stall_addr", {28'd0, match_addr}, {28'd0, e0.a});
            tick();
        end
        cyc(1'b1, 8'h55, 1'b1);
        cyc(1'b1, 8'h99, 1'b1);
        drain();

        // Randomized traffic against the model.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                drain();
                case ($urandom_range(0, 4))
                    0:       msk = '0;
                    1:       msk = mk(8'hF0);
                    2:       msk = mk(8'h0F);
                    default: msk = mk(8'hFF);
                endcase
                do_write(4'($urandom_range(0, 15)), wk(8'($urandom)), msk,
                         $urandom_range(0, 6) == 0);
            end else begin
                if ($urandom_range(0, 1) == 0) k = m_val[$urandom_range(0, 15)][7:0];
                else k = 8'($urandom);
                cyc($urandom_range(0, 9) < 7, k, $urandom_range(0, 3) != 0);
            end
        end
        drain();

        // Counter phase from a clean reset.
        rst = 1'b1; cmp_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < D; i++) m_vld[i] = 1'b0;
        exp_q.delete();
        tick();
        do_write(4'd0, wk(8'h01), mk(8'hFF), 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, (i < 6) ? 8'h01 : 8'h02, 1'b1);
        drain();
        chk("stat_lookups", stat_lookups, EXP_LK);
        chk("stat_hits", stat_hits, EXP_HT);

        // Reset with a result in flight and a write in COMMIT.
        cmp_valid = 1'b1; cmp_din = wk(8'h01); match_ready = 1'b0;
        we = 1'b1; wr_addr = 4'd4; din = wk(8'h44); din_mask = mk(8'hFF); wr_delete = 1'b0;
        tick();
        we = 1'b0;
        chk("mid_busy_commit", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_match_valid", {31'd0, match_valid}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_cmp_ready", {31'd0, cmp_ready}, 32'd0);
        chk("mid_stat_lk", stat_lookups, 32'd0);
        chk("mid_stat_ht", stat_hits, 32'd0);
        rst = 1'b0; cmp_valid = 1'b0; match_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < D; i++) m_vld[i] = 1'b0;
        tick();
        chk("post_rst_valid", {31'd0, match_valid}, 32'd0);
        apply_vec('{8'h01, 1'b0, 1'b0, 4'd0});
        apply_vec('{8'h44, 1'b0, 1'b0, 4'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tcam_match_engine.md
Name: tcam_match_engine

Overview:
- Parametrised ternary CAM (TCAM) for the menshen match stage, replacing the fixed binary CAM wrapper.
- Each entry holds a value, a per-bit care mask and a valid bit.
- Lookups run through a 2-stage pipeline with valid/ready handshakes on both sides. The result is a lowest-index priority match plus a multi-match flag.
- Sits between the key extractor and the action-RAM address path. The control plane writes and deletes entries through a single write port.

Parameters:
- C_DEPTH, 16, number of entries; must equal 2**ADDR_BITS.
- ADDR_BITS, 4, entry address width.
- C_WIDTH, 205, key/value/mask width in bits.

Ports:
- CLK  in  1  sole clock.
- RST  in  1  synchronous active-high reset, sampled on the rising edge of CLK.
- CMP_VALID  in  1  lookup key valid.
- CMP_READY  out  1  engine accepts a key this cycle.
- CMP_DIN  in  C_WIDTH  lookup key.
- MATCH_VALID  out  1  result valid.
- MATCH_READY  in  1  downstream accepts the result.
- MATCH  out  1  at least one valid entry matched.
- MATCH_MULTI  out  1  more than one valid entry matched.
- MATCH_ADDR  out  ADDR_BITS  lowest matching index; 0 when MATCH=0.
- WE  in  1  write request.
- WR_DELETE  in  1  with WE: invalidate the entry instead of writing it.
- WR_ADDR  in  ADDR_BITS  target entry.
- DIN  in  C_WIDTH  entry value.
- DIN_MASK  in  C_WIDTH  care mask; 1 = bit compared, 0 = don't care.
- BUSY  out  1  write port busy; WE is ignored while BUSY=1.
- STAT_LOOKUPS  out  32  lookup counter (optional feature).
- STAT_HITS  out  32  hit counter (optional feature).

Behaviour:
- Reset values:
  - All valid bits cleared; value and mask arrays are not reset.
  - Both pipeline valids = 0; pending write dropped.
  - BUSY=0, MATCH_VALID=0, MATCH=0, MATCH_MULTI=0, MATCH_ADDR=0, STAT_* = 0.
  - CMP_READY=0 in any cycle where RST=1.
- Match rule, per entry i:
  - hit[i] = valid[i] & (((CMP_DIN ^ value[i]) & mask[i]) == 0).
  - An all-zero mask matches every key.
- Pipeline:
  - advance = !MATCH_VALID | MATCH_READY; CMP_READY = advance & !RST.
  - S1 registers hit[C_DEPTH-1:0] when CMP_VALID & CMP_READY.
  - S2 registers the priority encode of S1: MATCH_ADDR = lowest i with hit, MATCH = |hit, MATCH_MULTI = popcount>1.
  - Latency: key accepted in cycle N gives its result visible in cycle N+2 with no stall.
  - Throughput: 1 lookup/cycle.
- Stall: while MATCH_VALID & !MATCH_READY, both stages hold and CMP_READY=0. No result is ever dropped or duplicated.
- Bubbles: an S1 bubble propagates as MATCH_VALID=0 in the next cycle; S2 never holds a bubble while S1 holds data and advance=1.
- Write FSM, states IDLE -> COMMIT -> IDLE:
  - IDLE: WE=1 latches WR_ADDR/DIN/DIN_MASK/WR_DELETE and moves to COMMIT. BUSY is high during COMMIT.
  - COMMIT: at the end of the cycle, updates value/mask and sets valid (or only clears valid if WR_DELETE), then returns to IDLE.
  - Peak rate: one write per 2 cycles. WE asserted during COMMIT is ignored, not queued.
- Write/lookup ordering:
  - A key accepted at or before the COMMIT cycle compares against the old entry.
  - A key accepted in the cycle after COMMIT or later sees the new entry.
  - Lookups are never blocked by writes.
- Reset mid-operation: in-flight results and the pending write are discarded; no partial entry update.

Optional Feature:
- Macro: TCAM_STATS_EN.
- Defined:
  - STAT_LOOKUPS increments on each accepted key.
  - STAT_HITS increments on each result handshake (MATCH_VALID & MATCH_READY) with MATCH=1.
  - Both are 32-bit and saturate at 0xFFFFFFFF; both clear on RST.
- Undefined: no counter logic; STAT_LOOKUPS and STAT_HITS are tied to 0. Ports remain present.

Decomposition:
- Package menshen_cam_pkg:
  - Default width/depth constants.
  - Write FSM state encoding (IDLE=0, COMMIT=1).
  - Counter width constant (32).
- Sub-module tcam_prio_enc (parametrised by C_DEPTH/ADDR_BITS), purely combinational:
  - Inputs: hit vector.
  - Outputs: addr, any, multi.
  - Instantiated in front of the S2 registers.

Test Plan:
- Write entry 3 value=0xA5 with full mask, wait for BUSY to fall, look up 0xA5 -> 2 cycles after accept: MATCH=1, MATCH_ADDR=3, MATCH_MULTI=0; look up 0xA4 -> MATCH=0, MATCH_ADDR=0.
- Entry 2 with mask=0 and entry 5 exact 0x11; look up 0x11 -> MATCH_ADDR=2, MATCH_MULTI=1; delete entry 2, look up 0x11 again -> MATCH_ADDR=5, MATCH_MULTI=0.
- Back-to-back keys with MATCH_READY held low for 4 cycles -> CMP_READY=0 and results stable for those 4 cycles; on release, results emerge in order with no loss.
- WE pulsed on 2 consecutive cycles -> only the first write takes effect; BUSY=1 exactly in the COMMIT cycle.
- Overlap a write to entry 7 with lookups accepted at COMMIT and COMMIT+1 -> the first sees the old contents, the second the new.
- With TCAM_STATS_EN defined: 10 accepted lookups, 6 hits -> STAT_LOOKUPS=10, STAT_HITS=6. Assert RST mid-stream -> counters, MATCH_VALID and BUSY all 0 the next cycle, and all entries invalid.
